// File: rtl/fetch_stage_pkg.sv
// Shared constants and next-PC path selection for the instruction-fetch stage.
package fetch_stage_pkg;

    localparam int unsigned PC_W    = 8;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned PC_STEP = 4;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    // Which update the PC and IF/ID register take on the coming edge.
    typedef enum logic [1:0] {
        PC_HOLD     = 2'd0,
        PC_SEQ      = 2'd1,
        PC_REDIRECT = 2'd2
    } pc_sel_e;

    // Priority: redirect beats stall beats sequential fetch.
    function automatic pc_sel_e pc_select(input logic redirect_valid, input logic stall);
        pc_sel_e sel;
        sel = PC_SEQ;
        if (redirect_valid) begin
            sel = PC_REDIRECT;
        end else if (stall) begin
            sel = PC_HOLD;
        end
        return sel;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-address / instruction-word bus between the fetch stage and InstructionMemory.
interface fetch_stage_if #(
    parameter int unsigned PC_W    = 8,
    parameter int unsigned INSTR_W = 32
);
    logic [PC_W-1:0]    imem_pc;
    logic [INSTR_W-1:0] imem_instruct;

    modport master (output imem_pc, input imem_instruct);
    modport slave  (input imem_pc, output imem_instruct);
endinterface

// File: rtl/fetch_stage_program_counter.sv
// Program counter register with redirect / hold / sequential next-PC select.
module program_counter
    import fetch_stage_pkg::*;
#(
    parameter int unsigned     PC_W     = fetch_stage_pkg::PC_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_target,
    output logic [PC_W-1:0] pc,
    output logic            misalign
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic            misalign_q, misalign_d;
    pc_sel_e         sel_c;

    // Next-PC select; redirect targets are forced to word alignment.
    always_comb begin
        pc_d       = pc_q;
        misalign_d = 1'b0;
        sel_c      = pc_select(redirect_valid, stall);
        case (sel_c)
            PC_REDIRECT: begin
                pc_d       = {redirect_target[PC_W-1:2], 2'b00};
                misalign_d = |redirect_target[1:0];
            end
            PC_SEQ:  pc_d = pc_q + PC_W'(PC_STEP);
            default: pc_d = pc_q;
        endcase
    end

    // PC and misalign pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc       = pc_q;
    assign misalign = misalign_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, IF/ID pipeline register and delivered-instruction counter.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned     PC_W     = fetch_stage_pkg::PC_W,
    parameter int unsigned     INSTR_W  = fetch_stage_pkg::INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned     CNT_W    = fetch_stage_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    fetch_stage_if.master      imem,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_target,
    output logic               ifid_valid,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [PC_W-1:0]    ifid_pc,
    output logic [PC_W-1:0]    ifid_pc_plus4,
    output logic               misalign,
    output logic [CNT_W-1:0]   fetch_count
);

    logic [PC_W-1:0]    pc;
    logic               ifid_valid_q, ifid_valid_d;
    logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
    logic [PC_W-1:0]    ifid_pc_q, ifid_pc_d;
    logic [PC_W-1:0]    ifid_pc_plus4_q, ifid_pc_plus4_d;
    logic [CNT_W-1:0]   fetch_count_q, fetch_count_d;
    pc_sel_e            sel_c;

    program_counter #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .pc              (pc),
        .misalign        (misalign)
    );

    assign imem.imem_pc = pc;

    // IF/ID load, flush on redirect (pc fields kept), hold on stall; saturating delivery count.
    always_comb begin
        ifid_valid_d    = ifid_valid_q;
        ifid_instr_d    = ifid_instr_q;
        ifid_pc_d       = ifid_pc_q;
        ifid_pc_plus4_d = ifid_pc_plus4_q;
        fetch_count_d   = fetch_count_q;
        sel_c           = pc_select(redirect_valid, stall);
        case (sel_c)
            PC_REDIRECT: begin
                ifid_valid_d = 1'b0;
                ifid_instr_d = INSTR_W'(NOP_INSTR);
            end
            PC_SEQ: begin
                ifid_valid_d    = 1'b1;
                ifid_instr_d    = imem.imem_instruct;
                ifid_pc_d       = pc;
                ifid_pc_plus4_d = pc + PC_W'(PC_STEP);
                if (fetch_count_q != {CNT_W{1'b1}}) begin
                    fetch_count_d = fetch_count_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // IF/ID pipeline register and counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_valid_q    <= 1'b0;
            ifid_instr_q    <= INSTR_W'(NOP_INSTR);
            ifid_pc_q       <= '0;
            ifid_pc_plus4_q <= '0;
            fetch_count_q   <= '0;
        end else begin
            ifid_valid_q    <= ifid_valid_d;
            ifid_instr_q    <= ifid_instr_d;
            ifid_pc_q       <= ifid_pc_d;
            ifid_pc_plus4_q <= ifid_pc_plus4_d;
            fetch_count_q   <= fetch_count_d;
        end
    end

    assign ifid_valid    = ifid_valid_q;
    assign ifid_instr    = ifid_instr_q;
    assign ifid_pc       = ifid_pc_q;
    assign ifid_pc_plus4 = ifid_pc_plus4_q;
    assign fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand sequences, randomized run against a model.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [7:0]  redirect_target;

    logic        ifid_valid, misalign;
    logic [31:0] ifid_instr;
    logic [7:0]  ifid_pc, ifid_pc_plus4;
    logic [15:0] fetch_count;

    logic        s_valid, s_mis;
    logic [31:0] s_instr;
    logic [7:0]  s_pc, s_pc4;
    logic [3:0]  s_count;

    logic [31:0] mem [64];

    int checks = 0;
    int errors = 0;

    fetch_stage_if #(.PC_W(8), .INSTR_W(32)) imem_a ();
    fetch_stage_if #(.PC_W(8), .INSTR_W(32)) imem_b ();

    // Instruction memory: combinational word read.
    assign imem_a.imem_instruct = mem[imem_a.imem_pc[7:2]];
    assign imem_b.imem_instruct = mem[imem_b.imem_pc[7:2]];

    fetch_stage u_dut (
        .clk             (clk),
        .rst             (rst),
        .imem            (imem_a.master),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .ifid_valid      (ifid_valid),
        .ifid_instr      (ifid_instr),
        .ifid_pc         (ifid_pc),
        .ifid_pc_plus4   (ifid_pc_plus4),
        .misalign        (misalign),
        .fetch_count     (fetch_count)
    );

    // Narrow-counter instance so saturation is reachable quickly.
    fetch_stage #(.CNT_W(4)) u_dut4 (
        .clk             (clk),
        .rst             (rst),
        .imem            (imem_b.master),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .ifid_valid      (s_valid),
        .ifid_instr      (s_instr),
        .ifid_pc         (s_pc),
        .ifid_pc_plus4   (s_pc4),
        .misalign        (s_mis),
        .fetch_count     (s_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst, stall, rv;
        logic [7:0]  tgt;
        logic [7:0]  e_pc;
        logic        e_v;
        logic [31:0] e_instr;
        logic [7:0]  e_ipc, e_ipc4;
        logic        e_mis;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic r, input logic s, input logic rv, input logic [7:0] t);
        rst             = r;
        stall           = s;
        redirect_valid  = rv;
        redirect_target = t;
        @(posedge clk);
        #1;
    endtask

    // Behavioural reference written directly from the stage rules.
    int          m_pc, m_ipc, m_ipc4, m_cnt;
    logic        m_valid, m_mis;
    logic [31:0] m_instr;

    task automatic model_step(input logic r, input logic s, input logic rv, input int t);
        if (r) begin
            m_pc = 0; m_valid = 0; m_instr = 0; m_ipc = 0; m_ipc4 = 0; m_mis = 0; m_cnt = 0;
        end else if (rv) begin
            m_pc    = t - (t % 4);
            m_mis   = (t % 4) != 0;
            m_valid = 0;
            m_instr = 0;
        end else if (s) begin
            m_mis = 0;
        end else begin
            m_instr = mem[m_pc / 4];
            m_ipc   = m_pc;
            m_ipc4  = (m_pc + 4) % 256;
            m_valid = 1;
            m_pc    = (m_pc + 4) % 256;
            m_mis   = 0;
            m_cnt++;
        end
    endtask

    initial begin
        for (int k = 0; k < 64; k++) mem[k] = 32'hA500_0000 + 32'(k);
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 8'h00;

        //                  rst  stl  rv   tgt     e_pc   v    instr          ipc    ipc4   mis  cnt
        vecs.push_back(vec_t'{1'b1,1'b0,1'b0,8'h00, 8'h00,1'b0,32'h0,         8'h00,8'h00,1'b0,16'd0});
        vecs.push_back(vec_t'{1'b0,1'b0,1'b0,8'h00, 8'h04,1'b1,32'hA500_0000,8'h00,8'h04,1'b0,16'd1});
        vecs.push_back(vec_t'{1'b0,1'b0,1'b0,8'h00, 8'h08,1'b1,32'hA500_0001,8'h04,8'h08,1'b0,16'd2});
        vecs.push_back(vec_t'{1'b0,1'b0,1'b0,8'h00, 8'h0C,1'b1,32'hA500_0002,8'h08,8'h0C,1'b0,16'd3});
        vecs.push_back(vec_t'{1'b0,1'b0,1'b0,8'h00, 8'h10,1'b1,32'hA500_0003,8'h0C,8'h10,1'b0,16'd4});
        vecs.push_back(vec_t'{1'b1,1'b0,1'b0,8'h00, 8'h00,1'b0,32'h0,         8'h00,8'h00,1'b0,16'd0});
        vecs.push_back(vec_t'{1'b0,1'b0,1'b0,8'h00, 8'h04,1'b1,32'hA500_0000,8'h00,8'h04,1'b0,16'd1});
        vecs.push_back(vec_t'{1'b0,1'b0,1'b0,8'h00, 8'h08,1'b1,32'hA500_0001,8'h04,8'h08,1'b0,16'd2});
        vecs.push_back(vec_t'{1'b0,1'b1,1'b0,8'h00, 8'h08,1'b1,32'hA500_0001,8'h04,8'h08,1'b0,16'd2});
        vecs.push_back(vec_t'{1'b0,1'b1,1'b0,8'h00, 8'h08,1'b1,32'hA500_0001,8'h04,8'h08,1'b0,16'd2});
        vecs.push_back(vec_t'{1'b0,1'b0,1'b0,8'h00, 8'h0C,1'b1,32'hA500_0002,8'h08,8'h0C,1'b0,16'd3});
        vecs.push_back(vec_t'{1'b0,1'b0,1'b1,8'h40, 8'h40,1'b0,32'h0,         8'h08,8'h0C,1'b0,16'd3});
        vecs.push_back(vec_t'{1'b0,1'b0,1'b0,8'h00, 8'h44,1'b1,32'hA500_0010,8'h40,8'h44,1'b0,16'd4});
        vecs.push_back(vec_t'{1'b0,1'b1,1'b1,8'h20, 8'h20,1'b0,32'h0,         8'h40,8'h44,1'b0,16'd4});
        vecs.push_back(vec_t'{1'b0,1'b0,1'b0,8'h00, 8'h24,1'b1,32'hA500_0008,8'h20,8'h24,1'b0,16'd5});
        vecs.push_back(vec_t'{1'b0,1'b0,1'b1,8'h13, 8'h10,1'b0,32'h0,         8'h20,8'h24,1'b1,16'd5});
        vecs.push_back(vec_t'{1'b0,1'b0,1'b0,8'h00, 8'h14,1'b1,32'hA500_0004,8'h10,8'h14,1'b0,16'd6});
        vecs.push_back(vec_t'{1'b0,1'b0,1'b1,8'hFC, 8'hFC,1'b0,32'h0,         8'h10,8'h14,1'b0,16'd6});
        vecs.push_back(vec_t'{1'b0,1'b0,1'b0,8'h00, 8'h00,1'b1,32'hA500_003F,8'hFC,8'h00,1'b0,16'd7});
        vecs.push_back(vec_t'{1'b0,1'b1,1'b0,8'h00, 8'h00,1'b1,32'hA500_003F,8'hFC,8'h00,1'b0,16'd7});
        vecs.push_back(vec_t'{1'b1,1'b1,1'b0,8'h00, 8'h00,1'b0,32'h0,         8'h00,8'h00,1'b0,16'd0});
        vecs.push_back(vec_t'{1'b0,1'b0,1'b0,8'h00, 8'h04,1'b1,32'hA500_0000,8'h00,8'h04,1'b0,16'd1});

        // Directed vector table.
        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].stall, vecs[i].rv, vecs[i].tgt);
            check($sformatf("v%0d imem_pc", i),       32'(imem_a.imem_pc), 32'(vecs[i].e_pc));
            check($sformatf("v%0d ifid_valid", i),    32'(ifid_valid),     32'(vecs[i].e_v));
            check($sformatf("v%0d ifid_instr", i),    ifid_instr,          vecs[i].e_instr);
            check($sformatf("v%0d ifid_pc", i),       32'(ifid_pc),        32'(vecs[i].e_ipc));
            check($sformatf("v%0d ifid_pc_plus4", i), 32'(ifid_pc_plus4),  32'(vecs[i].e_ipc4));
            check($sformatf("v%0d misalign", i),      32'(misalign),       32'(vecs[i].e_mis));
            check($sformatf("v%0d fetch_count", i),   32'(fetch_count),    32'(vecs[i].e_cnt));
        end

        // Reset beats a simultaneous misaligned redirect.
        apply(1'b1, 1'b0, 1'b1, 8'h13);
        check("rst_vs_redirect pc", 32'(imem_a.imem_pc), 32'h00);
        check("rst_vs_redirect mis", 32'(misalign), 32'h0);
        // Misalign pulse is cleared by a following stall.
        apply(1'b0, 1'b0, 1'b1, 8'h22);
        check("redir22 pc", 32'(imem_a.imem_pc), 32'h20);
        check("redir22 mis", 32'(misalign), 32'h1);
        apply(1'b0, 1'b1, 1'b0, 8'h00);
        check("stall_after_mis pc", 32'(imem_a.imem_pc), 32'h20);
        check("stall_after_mis mis", 32'(misalign), 32'h0);
        check("stall_after_mis valid", 32'(ifid_valid), 32'h0);

        // Counter saturation on the 4-bit instance after 20 deliveries.
        apply(1'b1, 1'b0, 1'b0, 8'h00);
        for (int c = 0; c < 20; c++) apply(1'b0, 1'b0, 1'b0, 8'h00);
        check("count16 after 20", 32'(fetch_count), 32'd20);
        check("count4 saturated", 32'(s_count), 32'd15);
        check("imem_pc after 20", 32'(imem_a.imem_pc), 32'd80);

        // Randomized run against the reference model.
        apply(1'b1, 1'b0, 1'b0, 8'h00);
        model_step(1'b1, 1'b0, 1'b0, 0);
        for (int n = 0; n < 1500; n++) begin
            logic r, s, rv;
            logic [7:0] t;
            r  = ($urandom % 64) == 0;
            s  = ($urandom % 4) == 0;
            rv = ($urandom % 6) == 0;
            t  = 8'($urandom % 256);
            apply(r, s, rv, t);
            model_step(r, s, rv, int'(t));
            check("rnd imem_pc",       32'(imem_a.imem_pc), 32'(m_pc));
            check("rnd ifid_valid",    32'(ifid_valid),     32'(m_valid));
            check("rnd ifid_instr",    ifid_instr,          m_instr);
            check("rnd ifid_pc",       32'(ifid_pc),        32'(m_ipc));
            check("rnd ifid_pc_plus4", 32'(ifid_pc_plus4),  32'(m_ipc4));
            check("rnd misalign",      32'(misalign),       32'(m_mis));
            check("rnd fetch_count",   32'(fetch_count),    32'((m_cnt > 65535) ? 65535 : m_cnt));
            check("rnd fetch_count4",  32'(s_count),        32'((m_cnt > 15) ? 15 : m_cnt));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
